mem_port: RTL and testbench
===========================

// Module: mem_port
// PURPOSE
//  Memory-access stage between the multi-cycle controller/datapath and a variable-latency unified
//  instruction/data memory. Selects PC or ALUOut as address (IorD), runs a req/ack bus cycle,
//  captures fetched words into IR and loaded words into MDR, and raises stall to freeze the
//  controller FSM until the access completes. Detects misaligned addresses and bus timeouts.
// PARAMETERS
//  MAX_WAIT   255   BUSY cycles without mem_ack before the access is aborted (1..255)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  IorD       in   1   from ctrl: 1 = data access at ALUOut, 0 = instruction access at PC
//  MemWrite   in   1   from ctrl: with IorD=1, store; else load
//  IRWrite    in   1   from ctrl: instruction fetch request (IorD=0)
//  PC         in   32  fetch address
//  ALUOut     in   32  data address
//  WriteData  in   32  store data (rt value)
//  IR         out  32  instruction register
//  MDR        out  32  memory data register (lw result)
//  stall      out  1   1 = ctrl must hold state and all enables this cycle
//  bus_err    out  1   sticky: misaligned or timed-out access
//  mem_req    out  1   bus request, registered
//  mem_we     out  1   bus write enable, registered
//  mem_addr   out  32  bus word address, registered
//  mem_wdata  out  32  bus write data, registered
//  mem_rdata  in   32  bus read data, valid when mem_ack=1
//  mem_ack    in   1   bus completion, one cycle per access
// BEHAVIOUR
//  - Reset (rst=0, async): IR, MDR, mem_addr, mem_wdata = 0; mem_req, mem_we, bus_err = 0;
//    FSM -> IDLE; wait counter = 0; stall forced 0 while rst=0. A bus cycle in flight is dropped.
//  - Request: acc = IRWrite | IorD. IorD=1 wins: data access; IR is not written.
//  - FSM IDLE -> BUSY: acc=1 and address aligned. That cycle stall=1 combinationally; at the edge
//    mem_req<=1, mem_we<=IorD&MemWrite, mem_addr<=IorD?ALUOut:PC, mem_wdata<=WriteData.
//  - Misaligned in IDLE: acc=1 and addr[1:0]!=0. No bus cycle. bus_err<=1, stall=0 that cycle,
//    IR/MDR unchanged. The controller advances.
//  - BUSY: mem_req/we/addr/wdata held stable. stall=1 unless mem_ack=1.
//    On mem_ack: stall=0 in the same cycle. At the edge: fetch IR<=mem_rdata, load MDR<=mem_rdata,
//    store no capture; mem_req<=0; -> IDLE.
//  - Minimum latency is 2 cycles (request cycle + ack in the first BUSY cycle). Each wait cycle adds 1.
//  - Wait counter: cleared on entering BUSY, +1 per BUSY cycle without ack.
//    Timeout when the count reaches MAX_WAIT with no ack: stall=0 that cycle, bus_err<=1,
//    mem_req<=0, -> IDLE, IR/MDR unchanged. If ack and timeout coincide, ack wins (normal completion).
//  - mem_ack while in IDLE is ignored.
//  - Back-to-back accesses (smem then sif) take a fresh IDLE request cycle, with no bubble beyond it.
//  - bus_err clears only on reset. The ctrl is not halted by bus_err.
//  - Mid-access changes of IorD/PC/ALUOut are ignored because the address is latched at BUSY entry.
// TESTING
//  - Fetch: PC=0x00003000, IRWrite=1, ack with 0x20080005 in the 1st BUSY cycle -> stall 1 then 0;
//    mem_addr=0x3000, mem_we=0; next cycle IR=0x20080005.
//  - Load: IorD=1, MemWrite=0, ALUOut=0x10, ack after 3 waits with 0xDEADBEEF -> stall high for
//    4 cycles; MDR=0xDEADBEEF; IR unchanged.
//  - Store: IorD=1, MemWrite=1, ALUOut=0x20, WriteData=0x12345678 -> mem_we=1,
//    mem_wdata=0x12345678 held until ack; MDR unchanged.
//  - Timeout: MAX_WAIT=4, never ack -> stall drops after 4 BUSY cycles; bus_err=1; mem_req=0;
//    IR unchanged. A later fetch still completes.
//  - Misaligned: ALUOut=0x00000002 load -> mem_req stays 0; bus_err=1; stall=0 in the same cycle.
//  - Reset mid-BUSY: drive rst=0 during a wait -> mem_req=0 immediately; IR=MDR=0; bus_err=0;
//    FSM in IDLE after release.

Source files
------------

// File: rtl/mem_port_if.sv
// Bus between the memory-access stage and the unified instruction/data memory.
// The stage drives request, write enable, address and write data; memory returns read data and ack.
interface mem_port_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mem_port.sv
// Memory-access stage: latches the address into a req/ack bus cycle and captures fetched or loaded
// data into IR or MDR. Stalls the controller from the request cycle until ack, timeout or misalign.
module mem_port #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IorD,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic [31:0] PC,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   output logic [31:0] IR,
   output logic [31:0] MDR,
   output logic        stall,
   output logic        bus_err,
   mem_port_if.master  bus
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        acc;
   logic [31:0] req_addr;
   logic        aligned;

   logic        start;
   logic        misalign;
   logic        done;
   logic        timeout;

   logic [7:0]  wait_cnt;
   logic        is_data_q;

   assign acc      = IRWrite | IorD;
   assign req_addr = IorD ? ALUOut : PC;
   assign aligned  = (req_addr[1:0] == 2'b00);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // wait_cnt counts BUSY cycles already spent without ack; the access is
   // aborted in the first BUSY cycle that finds MAX_WAIT of them behind it.
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      start    = 1'b0;
      misalign = 1'b0;
      done     = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc) begin
               if (aligned) begin
                  start   = 1'b1;
                  stall   = 1'b1;
                  state_d = BUSY;
               end else begin
                  misalign = 1'b1;
               end
            end
         end
         BUSY: begin
            if (bus.mem_ack) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (wait_cnt == WAIT_LIMIT) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (!rst) begin
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'h0;
         bus.mem_wdata <= 32'h0;
         is_data_q     <= 1'b0;
         wait_cnt      <= 8'h0;
      end else if (start) begin
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= IorD & MemWrite;
         bus.mem_addr  <= req_addr;
         bus.mem_wdata <= WriteData;
         is_data_q     <= IorD;
         wait_cnt      <= 8'h0;
      end else if (done || timeout) begin
         bus.mem_req <= 1'b0;
         bus.mem_we  <= 1'b0;
      end else if (state_q == BUSY) begin
         wait_cnt <= wait_cnt + 8'h1;
      end
   end

   // Stores complete without capturing anything; the kind of access was latched at BUSY entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         IR  <= 32'h0;
         MDR <= 32'h0;
      end else if (done) begin
         if (!is_data_q) begin
            IR <= bus.mem_rdata;
         end else if (!bus.mem_we) begin
            MDR <= bus.mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_err <= 1'b0;
      end else if (misalign || timeout) begin
         bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port (MAX_WAIT=4): fetch, load, store, idle ack, misalign, reset, timeout.
module tb_mem_port;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        IorD;
   logic        MemWrite;
   logic        IRWrite;
   logic [31:0] PC;
   logic [31:0] ALUOut;
   logic [31:0] WriteData;
   logic [31:0] IR;
   logic [31:0] MDR;
   logic        stall;
   logic        bus_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_if bus ();

   mem_port #(.MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .IorD      (IorD),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .PC        (PC),
      .ALUOut    (ALUOut),
      .WriteData (WriteData),
      .IR        (IR),
      .MDR       (MDR),
      .stall     (stall),
      .bus_err   (bus_err),
      .bus       (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One access: request cycle, then `waits` BUSY cycles without ack, then the ack cycle.
   // Returns the number of cycles in which stall was seen high.
   task automatic do_access(input logic iord, input logic irw, input logic mw,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd, output int nstall);
      IorD      = iord;
      IRWrite   = irw;
      MemWrite  = mw;
      WriteData = wd;
      if (iord) ALUOut = addr;
      else      PC     = addr;
      nstall = 0;
      @(negedge clk);
      if (stall) nstall++;
      chk("req_idle", {31'h0, bus.mem_req}, 32'h0);
      tick;
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
         end
         @(negedge clk);
         if (stall) nstall++;
         chk("busy_req",   {31'h0, bus.mem_req}, 32'h1);
         chk("busy_addr",  bus.mem_addr, addr);
         chk("busy_we",    {31'h0, bus.mem_we}, {31'h0, iord & mw});
         chk("busy_wdata", bus.mem_wdata, wd);
         // address and data must stay latched even when the controller inputs move
         PC        = 32'hFFFF_FFF0;
         ALUOut    = 32'hFFFF_FFE0;
         WriteData = 32'hA5A5_A5A5;
         tick;
      end
      bus.mem_ack = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      chk("req_done", {31'h0, bus.mem_req}, 32'h0);
   endtask

   initial begin
      int ns;
      bit seen_drop;
      IorD          = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b1;
      PC            = 32'h0;
      ALUOut        = 32'h0;
      WriteData     = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;

      // reset: stall forced low even though a fetch is requested
      repeat (2) @(negedge clk);
      chk("rst_stall",   {31'h0, stall}, 32'h0);
      chk("rst_ir",      IR, 32'h0);
      chk("rst_mdr",     MDR, 32'h0);
      chk("rst_req",     {31'h0, bus.mem_req}, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst_addr",    bus.mem_addr, 32'h0);
      IRWrite = 1'b0;
      rst     = 1'b1;
      tick;

      do_access(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 0, 32'h2008_0005, ns);
      chk("fetch_stall", ns, 1);
      chk("fetch_ir",    IR, 32'h2008_0005);

      do_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, ns);
      chk("load_stall", ns, 4);
      chk("load_mdr",   MDR, 32'hDEAD_BEEF);
      chk("load_ir",    IR, 32'h2008_0005);

      do_access(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 2, 32'hBADB_AD00, ns);
      chk("store_stall", ns, 3);
      chk("store_mdr",   MDR, 32'hDEAD_BEEF);
      chk("store_ir",    IR, 32'h2008_0005);

      // back-to-back fetch straight after the store
      do_access(1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h0, 0, 32'h8C09_0010, ns);
      chk("b2b_stall", ns, 1);
      chk("b2b_ir",    IR, 32'h8C09_0010);

      // ack while idle is ignored
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1111_1111;
      @(negedge clk);
      chk("idle_ack_stall", {31'h0, stall}, 32'h0);
      tick;
      bus.mem_ack = 1'b0;
      chk("idle_ack_ir",  IR, 32'h8C09_0010);
      chk("idle_ack_mdr", MDR, 32'hDEAD_BEEF);
      chk("idle_ack_req", {31'h0, bus.mem_req}, 32'h0);

      // misaligned load
      IorD   = 1'b1;
      ALUOut = 32'h0000_0002;
      @(negedge clk);
      chk("mis_stall",   {31'h0, stall}, 32'h0);
      chk("mis_req",     {31'h0, bus.mem_req}, 32'h0);
      chk("mis_err_pre", {31'h0, bus_err}, 32'h0);
      tick;
      IorD = 1'b0;
      chk("mis_err", {31'h0, bus_err}, 32'h1);
      chk("mis_req_after", {31'h0, bus.mem_req}, 32'h0);
      chk("mis_mdr", MDR, 32'hDEAD_BEEF);

      // reset in the middle of a wait
      IorD   = 1'b1;
      ALUOut = 32'h0000_0030;
      tick;
      chk("mrst_req_busy", {31'h0, bus.mem_req}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("mrst_req",     {31'h0, bus.mem_req}, 32'h0);
      chk("mrst_ir",      IR, 32'h0);
      chk("mrst_mdr",     MDR, 32'h0);
      chk("mrst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("mrst_stall",   {31'h0, stall}, 32'h0);
      IorD = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick;
      @(negedge clk);
      chk("post_rst_stall", {31'h0, stall}, 32'h0);
      tick;

      // timeout: request cycle plus four waiting BUSY cycles stall, the fifth aborts
      IRWrite   = 1'b1;
      PC        = 32'h0000_0040;
      ns        = 0;
      seen_drop = 1'b0;
      for (int i = 0; i < 20 && !seen_drop; i++) begin
         @(negedge clk);
         if (stall) begin
            ns++;
            tick;
         end else begin
            seen_drop = 1'b1;
         end
      end
      chk("tmo_drop",  {31'h0, seen_drop}, 32'h1);
      chk("tmo_stall", ns, 5);
      chk("tmo_err_pre", {31'h0, bus_err}, 32'h0);
      tick;
      IRWrite = 1'b0;
      chk("tmo_err", {31'h0, bus_err}, 32'h1);
      chk("tmo_req", {31'h0, bus.mem_req}, 32'h0);
      chk("tmo_ir",  IR, 32'h0);

      do_access(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'hCAFE_F00D, ns);
      chk("after_tmo_stall", ns, 2);
      chk("after_tmo_ir",    IR, 32'hCAFE_F00D);
      chk("after_tmo_err",   {31'h0, bus_err}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
